// File: rtl/apa102_frame_tx.sv
// APA102 strand transmitter: sends start frame, NUM_LEDS LED words fetched from a
// one-cycle-latency pattern source, and END_WORDS all-ones end frames, with optional auto-refresh.
module apa102_frame_tx #(
  parameter int NUM_LEDS   = 12,
  parameter int CLK_DIV    = 64,
  parameter int END_WORDS  = (NUM_LEDS + 63) / 64,
  parameter int GAP_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_refresh,
  input  logic        uniform,
  output logic        rd_en,
  output logic [9:0]  rd_idx,
  input  logic [31:0] rd_data,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = $clog2(END_WORDS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LED   = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [PW-1:0] BIT_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0]    LAST_LED  = 10'(NUM_LEDS - 1);
  localparam logic [EW-1:0] LAST_END  = EW'(END_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [PW-1:0] phase_cnt;
  logic [4:0]    slot_cnt;
  logic [9:0]    led_cnt;
  logic [EW-1:0] end_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   shift_reg;
  logic [31:0]   hold;
  logic          uniform_reg;
  logic          fetch_d;

  logic          bit_end;
  logic          half_end;
  logic          word_end;
  logic          gap_expire;
  logic          launch;
  logic          fetch_go;
  logic [9:0]    fetch_idx;
  logic [31:0]   led_word;

  assign bit_end    = (phase_cnt == BIT_LAST);
  assign half_end   = (phase_cnt == HALF_LAST);
  assign word_end   = bit_end && (slot_cnt == 5'd31);
  assign gap_expire = (state == S_GAP) && (gap_cnt == GAP_LAST) && auto_refresh;
  assign launch     = ((state == S_IDLE) || (state == S_GAP)) && (start || gap_expire);
  assign led_word   = {3'b111, hold[28:0]};
  assign fetch_idx  = (state == S_START) ? 10'd0 : led_cnt + 10'd1;

  // Fetch the next LED word during the last bit of the current word, just in time for the load.
  assign fetch_go = bit_end && (slot_cnt == 5'd30) &&
                    ((state == S_START) ||
                     ((state == S_LED) && !uniform_reg && (led_cnt != LAST_LED)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      slot_cnt    <= '0;
      led_cnt     <= '0;
      end_cnt     <= '0;
      gap_cnt     <= '0;
      shift_reg   <= '0;
      hold        <= '0;
      uniform_reg <= 1'b0;
      fetch_d     <= 1'b0;
      rd_en       <= 1'b0;
      rd_idx      <= '0;
      sck         <= 1'b0;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      done    <= 1'b0;
      fetch_d <= rd_en;
      if (fetch_d) hold <= rd_data;

      if ((state == S_IDLE) || (state == S_GAP)) begin
        if (launch) begin
          state       <= S_START;
          busy        <= 1'b1;
          uniform_reg <= uniform;
          phase_cnt   <= '0;
          slot_cnt    <= '0;
          shift_reg   <= '0;
          mosi        <= 1'b0;
          sck         <= 1'b0;
        end else if (state == S_GAP) begin
          if (!auto_refresh) state <= S_IDLE;
          else               gap_cnt <= gap_cnt + 1'b1;
        end
      end else begin
        phase_cnt <= bit_end ? '0 : phase_cnt + 1'b1;
        if (half_end) sck <= 1'b1;
        if (fetch_go) begin
          rd_en  <= 1'b1;
          rd_idx <= fetch_idx;
        end
        if (bit_end) begin
          sck      <= 1'b0;
          slot_cnt <= slot_cnt + 1'b1;
          if (!word_end) begin
            shift_reg <= {shift_reg[30:0], 1'b0};
            mosi      <= shift_reg[30];
          end else if (state == S_START) begin
            state     <= S_LED;
            led_cnt   <= '0;
            shift_reg <= led_word;
            mosi      <= 1'b1;
          end else if ((state == S_LED) && (led_cnt != LAST_LED)) begin
            led_cnt   <= led_cnt + 10'd1;
            shift_reg <= led_word;
            mosi      <= 1'b1;
          end else if (state == S_LED) begin
            state     <= S_END;
            end_cnt   <= '0;
            shift_reg <= '1;
            mosi      <= 1'b1;
          end else if (end_cnt != LAST_END) begin
            end_cnt   <= end_cnt + 1'b1;
            shift_reg <= '1;
            mosi      <= 1'b1;
          end else begin
            // Final end bit complete: the gap timer starts on this same clk.
            state   <= auto_refresh ? S_GAP : S_IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            mosi    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apa102_frame_tx.sv
// Scoreboard bench for apa102_frame_tx: stimulus pushes expected words/fetches/dones,
// a negedge monitor decodes the SPI stream and pops/compares.
module tb_apa102_frame_tx;

  localparam int NUM_LEDS   = 3;
  localparam int CLK_DIV    = 2;
  localparam int END_WORDS  = 1;
  localparam int GAP_CYCLES = 10;
  localparam int FRAME_BITS = 32 * (1 + NUM_LEDS + END_WORDS);
  localparam int FRAME_CYC  = FRAME_BITS * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        auto_refresh;
  logic        uniform;
  logic        rd_en;
  logic [9:0]  rd_idx;
  logic [31:0] rd_data = 32'h0;
  logic        sck;
  logic        mosi;
  logic        busy;
  logic        done;

  apa102_frame_tx #(
    .NUM_LEDS(NUM_LEDS), .CLK_DIV(CLK_DIV), .END_WORDS(END_WORDS), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .auto_refresh(auto_refresh), .uniform(uniform),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .sck(sck), .mosi(mosi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] pat [NUM_LEDS];

  logic [31:0] exp_words[$];
  int          fetch_idx_q[$];
  int          fetch_rise_q[$];
  int          done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pattern source: one-cycle read latency, junk on idle cycles.
  initial forever begin
    @(posedge clk);
    if (rd_en) rd_data <= (int'(rd_idx) < NUM_LEDS) ? pat[rd_idx] : 32'hDEADBEEF;
    else       rd_data <= $urandom;
  end

  // Reference: what a frame should look like, straight from the frame format rules.
  task automatic push_frame(input bit uni);
    logic [31:0] w;
    exp_words.push_back(32'h0);
    for (int k = 0; k < NUM_LEDS; k++) begin
      w = uni ? pat[0] : pat[k];
      exp_words.push_back({3'b111, w[28:0]});
    end
    for (int k = 0; k < (uni ? 1 : NUM_LEDS); k++) begin
      fetch_idx_q.push_back(k);
      fetch_rise_q.push_back(32 * k + 31);
    end
    for (int e = 0; e < END_WORDS; e++) exp_words.push_back(32'hFFFFFFFF);
    done_q.push_back(FRAME_BITS);
  endtask

  // Monitor
  initial begin
    logic [31:0] word;
    logic        prev_sck, prev_mosi, prev_busy, rise_mosi;
    int          nbits, rise_cnt, frame_start, exp_i;
    word = 0; prev_sck = 0; prev_mosi = 0; prev_busy = 0; rise_mosi = 0;
    nbits = 0; rise_cnt = 0; frame_start = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sck = 0; prev_busy = 0; nbits = 0; rise_cnt = 0;
      end else begin
        if (busy && !prev_busy) frame_start = cyc;
        if (sck && !prev_sck) begin
          word = {word[30:0], mosi};
          rise_mosi = mosi;
          nbits++;
          rise_cnt++;
          check("busy_at_rise", {31'b0, busy}, 32'h1);
          if (nbits == 32) begin
            nbits = 0;
            if (exp_words.size() == 0) check("unexpected_word", word, 32'hXXXXXXXX);
            else begin
              $display("word %h", word);
              check("word", word, exp_words.pop_front());
            end
          end
        end
        if (!sck && prev_sck) check("mosi_stable_high", {31'b0, prev_mosi}, {31'b0, rise_mosi});
        if (rd_en) begin
          if (fetch_idx_q.size() == 0) check("unexpected_rd_en", {22'b0, rd_idx}, 32'hXXXXXXXX);
          else begin
            check("rd_idx", {22'b0, rd_idx}, fetch_idx_q.pop_front());
            check("rd_en_time", rise_cnt, fetch_rise_q.pop_front());
          end
        end
        if (done) begin
          if (done_q.size() == 0) check("unexpected_done", 32'h1, 32'h0);
          else begin
            exp_i = done_q.pop_front();
            check("done_bits", rise_cnt, exp_i);
            check("done_cycle", cyc - frame_start, FRAME_CYC);
            check("partial_bits", nbits, 0);
          end
          rise_cnt = 0;
        end
        prev_sck = sck; prev_mosi = mosi; prev_busy = busy;
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'h0, 32'h1);
    else begin
      check("sck_after_done", {31'b0, sck}, 32'h0);
      check("mosi_after_done", {31'b0, mosi}, 32'h0);
      check("busy_after_done", {31'b0, busy}, 32'h0);
    end
  endtask

  task automatic send_frame(input bit uni, input int poke);
    push_frame(uni);
    uniform = uni;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    uniform = 1'($urandom);
    check("busy_rise", {31'b0, busy}, 32'h1);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    check("rd_idx_hold", {22'b0, rd_idx}, uni ? 32'd0 : NUM_LEDS - 1);
    @(negedge clk);
  endtask

  initial begin
    int d, n, seen;
    reset = 1'b1; start = 1'b0; auto_refresh = 1'b0; uniform = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", {31'b0, sck}, 32'h0);
    check("rst_mosi", {31'b0, mosi}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_rd_en", {31'b0, rd_en}, 32'h0);
    check("rst_rd_idx", {22'b0, rd_idx}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed words, top bits of the second and third deliberately zero
    pat[0] = 32'h1F0000FF; pat[1] = 32'h00FF0000; pat[2] = 32'h0A5A5A5A;
    send_frame(1'b0, 0);
    // Start during a busy frame must be ignored, then a follow-up frame runs identically
    send_frame(1'b0, 100);
    send_frame(1'b0, 0);
    // Uniform colour
    pat[0] = 32'hE5123456; pat[1] = 32'h11111111; pat[2] = 32'h22222222;
    send_frame(1'b1, 0);
    // Randomised frames
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NUM_LEDS; k++) pat[k] = $urandom;
      send_frame(1'($urandom_range(0, 1)), 0);
    end

    // Auto-refresh: next frame begins GAP_CYCLES after done
    for (int k = 0; k < NUM_LEDS; k++) pat[k] = $urandom;
    auto_refresh = 1'b1;
    push_frame(1'b0);
    push_frame(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    d = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sck && n < 200);
    check("gap_to_first_rise", cyc - d, GAP_CYCLES + CLK_DIV);
    wait_done();
    repeat (3) @(negedge clk);
    auto_refresh = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy || sck) seen = 1;
    end
    check("no_frame_after_refresh_off", seen, 0);

    // Reset while a fetch strobe is high mid-frame
    for (int k = 0; k < NUM_LEDS; k++) pat[k] = $urandom;
    push_frame(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_en && rd_idx == 10'd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_rd_en_seen", {31'b0, rd_en}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("async_sck", {31'b0, sck}, 32'h0);
    check("async_mosi", {31'b0, mosi}, 32'h0);
    check("async_busy", {31'b0, busy}, 32'h0);
    check("async_rd_en", {31'b0, rd_en}, 32'h0);
    check("async_done", {31'b0, done}, 32'h0);
    exp_words.delete(); fetch_idx_q.delete(); fetch_rise_q.delete(); done_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(1'b0, 0);

    repeat (20) @(negedge clk);
    check("words_left", exp_words.size(), 0);
    check("fetches_left", fetch_idx_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
